// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding and default timing/FIFO parameters.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;
  localparam int unsigned UART_FIFO_DEPTH_DEFAULT   = 16;

  localparam int unsigned RX_STATE_W = 3;

  localparam logic [RX_STATE_W-1:0] RX_IDLE  = 3'd0;
  localparam logic [RX_STATE_W-1:0] RX_START = 3'd1;
  localparam logic [RX_STATE_W-1:0] RX_DATA  = 3'd2;
  localparam logic [RX_STATE_W-1:0] RX_STOP  = 3'd3;
  localparam logic [RX_STATE_W-1:0] RX_BREAK = 3'd4;

endpackage

// File: rtl/io_byte_fifo.sv
// Synchronous FIFO with wrap-bit pointers; shared between the RX and future TX paths.
module io_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_rx_io.sv
// 8N1 UART receiver buffering bytes in a FIFO and serving them over a req/done read port.
module uart_rx_io
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH_DEFAULT
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       RXD,
  output logic       io_ready,
  input  logic       io_read_req,
  output logic       io_done,
  output logic [7:0] io_rdata,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  logic [1:0]            sync_q;
  logic                  rxd_s;
  logic [RX_STATE_W-1:0] state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  pending_q, pending_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  cnt_exp;
  logic                  rx_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_dout;

  assign rxd_s   = sync_q[1];
  assign cnt_exp = (cnt_q == '0);

  io_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .push_i  (rx_push),
    .din_i   (shreg_q),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (fifo_dout)
  );

  // Receive FSM: mid-bit sampling driven by the down-counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    frame_err_d = frame_err_q;
    rx_push     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rxd_s) begin
          state_d = RX_START;
          cnt_d   = CNT_HALF;
        end
      end
      RX_START: begin
        if (cnt_exp) begin
          cnt_d = CNT_FULL;
          if (!rxd_s) begin
            state_d = RX_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_exp) begin
          cnt_d   = CNT_FULL;
          shreg_d = {rxd_s, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_exp) begin
          cnt_d = CNT_FULL;
          if (rxd_s) begin
            rx_push = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_BREAK: begin
        if (rxd_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Read port: one outstanding request, served as soon as the FIFO has data.
  always_comb begin
    pending_d = pending_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    fifo_pop  = pending_q && !fifo_empty;
    if (fifo_pop) begin
      pending_d = 1'b0;
      done_d    = 1'b1;
      rdata_d   = fifo_dout;
    end else if (io_read_req) begin
      pending_d = 1'b1;
    end
    ready_d   = !fifo_empty && !pending_d && !done_d;
    overrun_d = overrun_q || (rx_push && fifo_full && !fifo_pop);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      sync_q      <= 2'b11;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      sync_q      <= {sync_q[0], RXD};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
    end
  end

  assign io_ready     = ready_q;
  assign io_done      = done_q;
  assign io_rdata     = rdata_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;

endmodule

// File: doc/uart_rx_io.md
# uart_rx_io

Byte-stream source feeding the bootloader's IO read port. Receives 8N1 serial data on RXD, oversamples it against CLK, buffers received bytes in a small FIFO, and serves them one per request over the `io_read_req` / `io_ready` / `io_done` / `io_rdata` handshake. It sits between the board UART pin and the bootloader, and stays in place after boot as a general console RX path.

## Interface
- `CLKS_PER_BIT`, default 868: CLK cycles per bit (100 MHz / 115200); minimum 8.
- `FIFO_DEPTH`, default 16: byte entries; must be a power of 2 and at least 2.
- `CLK`  in  1  clock, all logic on posedge.
- `RSTN`  in  1  reset, synchronous, active-low.
- `RXD`  in  1  asynchronous serial input, idle high.
- `io_ready`  out  1  high when the FIFO holds at least one byte and no read is pending.
- `io_read_req`  in  1  one-cycle request for the next byte.
- `io_done`  out  1  one-cycle pulse; `io_rdata` is valid in this cycle.
- `io_rdata`  out  8  byte popped from the FIFO; holds its value until the next `io_done`.
- `rx_overrun`  out  1  sticky; a byte was dropped because the FIFO was full.
- `rx_frame_err`  out  1  sticky; a stop bit was sampled low.

## Operation
- Input sync: `RXD` passes through a 2-flop synchronizer; all decisions use the synchronized value. The synchronizer resets to 1.
- Receive FSM states:
  - `IDLE`: on synchronized RXD = 0, load bit counter = CLKS_PER_BIT/2 − 1 and go to `START`.
  - `START`: when the counter expires, if RXD = 0 go to `DATA` (bit index 0, counter = CLKS_PER_BIT − 1); else treat as a glitch and return to `IDLE`.
  - `DATA`: on each expiry, shift the sample in LSB-first. After bit 7, go to `STOP`.
  - `STOP`: on expiry, if RXD = 1, push the byte (or set `rx_overrun` if full) and return to `IDLE`. If RXD = 0, set `rx_frame_err`, drop the byte and go to `BREAK`.
  - `BREAK`: wait for RXD = 1, then go to `IDLE`.
- Counter: down-counter, width $clog2(CLKS_PER_BIT). Expiry means the counter equals 0; it reloads to CLKS_PER_BIT − 1 on expiry.
- FIFO: read/write pointers $clog2(FIFO_DEPTH)+1 bits wide with wrap. Full when the MSBs differ and the lower bits are equal; empty when the pointers are equal.
- Read port:
  - `io_read_req` sampled high sets `pending`.
  - While `pending` and the FIFO is non-empty: pop, register the byte into `io_rdata`, assert `io_done` for one cycle, and clear `pending`.
  - A request made while empty stays pending until a byte arrives.
  - `io_read_req` while already pending is ignored (no double pop).
- `io_ready` = !empty && !pending && !io_done.

## Timing
- Reset values:
  - `io_ready` = 0, `io_done` = 0, `io_rdata` = 8'h00.
  - `rx_overrun` = 0, `rx_frame_err` = 0.
  - FSM in `IDLE`, pointers 0, `pending` = 0.
- Reset mid-frame discards the partial byte and all FIFO contents.
- Read latency: `io_read_req` sampled at edge N (FIFO non-empty) gives `io_done` = 1 after edge N+1, for exactly one cycle. `io_ready` returns at the earliest after edge N+2.
- Push latency: a byte pushed at edge M is visible on `io_ready` after edge M+1.
- Simultaneous push and pop in one cycle are both honoured; the count is unchanged.
  - Push into an empty FIFO with pending set: the pop occurs on the next cycle.
  - Push when full in the same cycle as a pop is accepted, not overrun.
- Sample point is mid-bit: start bit at CLKS_PER_BIT/2, then every CLKS_PER_BIT cycles. Receive tolerance is at least ±3% baud mismatch.
- Back-to-back frames: a start edge is accepted in the first `IDLE` cycle after the stop bit.

## Structure
- Shared package `uart_pkg`:
  - RX FSM state encoding (3-bit localparams `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`, `RX_BREAK`).
  - `UART_CLKS_PER_BIT_DEFAULT` = 868.
  - `UART_FIFO_DEPTH_DEFAULT` = 16.
- Sub-module `io_byte_fifo`: synchronous FIFO with push/pop/full/empty/dout, parameter DEPTH. It is reusable for the planned TX path.
- Top level `uart_rx_io`: synchronizer, receive FSM, bit counter, and read-port pending logic.

## Test plan
- Single byte: CLKS_PER_BIT = 16, send 8'hA5; wait for `io_ready`, pulse req → `io_done` one cycle later with `io_rdata` = 8'hA5; `io_ready` is 0 afterwards.
- Bootloader header stream: send 00 00 00 08, 00 00 00 10, then 8 data bytes, driven by a bootloader-model requester → bytes arrive in order, no flags set, FIFO empty at end.
- Overrun: FIFO_DEPTH = 4, send 5 bytes with no reads → 4 bytes read back (first four), `rx_overrun` = 1 and stays set.
- Framing/glitch: a 3-cycle low pulse → no byte and no flag. A frame with stop bit low → `rx_frame_err` = 1 and no push; the next valid 8'h3C is received correctly after the line idles.
- Pending request: req while empty → no `io_done` until the byte 8'h7E completes, then `io_done` with 8'h7E exactly once. A second req during pending → no extra pop.
- Reset mid-frame: assert RSTN = 0 during data bit 4 with 2 bytes buffered → all outputs at reset values, FIFO empty; the next frame 8'h55 is received correctly.
